// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch decision/target and the EX/MEM
// pipeline register whose ALU result also feeds back as the Memory-stage forward source.
module execute_cycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Select 11 is illegal and falls back to the register-file value.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110: alu_result = src_a << src_b[4:0];
      3'b111: alu_result = src_a >> src_b[4:0];
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign PCSrcE    = zero & BranchE;
  assign PCTargetE = PCE + Imm_Ext_E;

  // Stores write the forwarded rs2 value, not the immediate-muxed SrcB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 2'b00;
      RD_M        <= 5'd0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= alu_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed-vector bench for execute_cycle with hand-computed expectations.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteE, MemWriteE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  execute_cycle #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ResultW(ResultW), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  task automatic idle();
    RegWriteE = 0; MemWriteE = 0; BranchE = 0; ALUSrcE = 0;
    ResultSrcE = 0; ALUControlE = 0;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    RD_E = 0; ForwardA_E = 0; ForwardB_E = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // load nonzero state, then pull reset low between edges
    @(negedge clk);
    idle();
    rst = 1;
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b10; RD_E = 5'd17;
    PCPlus4E = 32'h44; RD1_E = 32'h10; RD2_E = 32'h20; ALUControlE = 3'b000;
    step();
    vectors++;
    if (ALU_ResultM !== 32'h30 || RD_M !== 5'd17) begin
      miscompares++;
      $display("FAIL preload alu=%h rd=%0d, want alu=00000030 rd=17", ALU_ResultM, RD_M);
    end
    #2 rst = 0;
    #1;
    $display("reset async: alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%b",
             ALU_ResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM, ResultSrcM);
    vectors++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
      miscompares++;
      $display("FAIL reset_async alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%b, want all 0",
               ALU_ResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM, ResultSrcM);
    end
    step();
    vectors++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold alu=%h rd=%0d, want all 0 while rst low", ALU_ResultM, RD_M);
    end
    @(negedge clk);
    rst = 1;
    idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ALUControlE = 3'b000; RD1_E = 5; RD2_E = 7; ALUSrcE = 0; RD_E = 5'd3; RegWriteE = 1;
    #1;
    vectors++;
    if (ALU_ResultM !== 32'd0) begin
      miscompares++;
      $display("FAIL latency alu=%h before edge, want 00000000", ALU_ResultM);
    end
    step();
    $display("add 5+7: alu=%0d rd=%0d", ALU_ResultM, RD_M);
    vectors++;
    if (ALU_ResultM !== 32'd12 || RD_M !== 5'd3 || RegWriteM !== 1'b1) begin
      miscompares++;
      $display("FAIL add alu=%0d rd=%0d rw=%b, want 12 3 1", ALU_ResultM, RD_M, RegWriteM);
    end
    @(negedge clk);
    ForwardA_E = 2'b10; RD1_E = 0; ALUSrcE = 1; Imm_Ext_E = 3; ALUControlE = 3'b000;
    step();
    $display("add fwdM 12+3: alu=%0d", ALU_ResultM);
    vectors++;
    if (ALU_ResultM !== 32'd15) begin
      miscompares++;
      $display("FAIL fwd_m alu=%0d, want 15", ALU_ResultM);
    end
  endtask

  task automatic test_wb_forward();
    @(negedge clk);
    idle();
    ForwardB_E = 2'b01; ResultW = 32'hFFFF_FFFF; RD1_E = 1; RD2_E = 32'h55; ALUControlE = 3'b001;
    step();
    $display("sub fwdW 1-(-1): alu=%h", ALU_ResultM);
    vectors++;
    if (ALU_ResultM !== 32'd2) begin
      miscompares++;
      $display("FAIL fwd_w alu=%h, want 00000002", ALU_ResultM);
    end
    @(negedge clk);
    ForwardB_E = 2'b11; RD2_E = 1;
    step();
    $display("sub sel11 1-1: alu=%h", ALU_ResultM);
    vectors++;
    if (ALU_ResultM !== 32'd0) begin
      miscompares++;
      $display("FAIL sel11 alu=%h, want 00000000", ALU_ResultM);
    end
    @(negedge clk);
    idle();
    ForwardA_E = 2'b01; ResultW = 32'd100; RD1_E = 32'd7; RD2_E = 32'd1; ALUControlE = 3'b000;
    step();
    $display("add fwdW A 100+1: alu=%0d", ALU_ResultM);
    vectors++;
    if (ALU_ResultM !== 32'd101) begin
      miscompares++;
      $display("FAIL fwd_w_a alu=%0d, want 101", ALU_ResultM);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    idle();
    BranchE = 1; ALUControlE = 3'b001; RD1_E = 32'h40; RD2_E = 32'h40;
    PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF0;
    #1;
    $display("beq equal: pcsrc=%b target=%h", PCSrcE, PCTargetE);
    vectors++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h0000_00F0) begin
      miscompares++;
      $display("FAIL beq_taken pcsrc=%b target=%h, want 1 000000f0", PCSrcE, PCTargetE);
    end
    RD2_E = 32'h41;
    #1;
    $display("beq unequal: pcsrc=%b", PCSrcE);
    vectors++;
    if (PCSrcE !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_not_taken pcsrc=%b, want 0", PCSrcE);
    end
    RD2_E = 32'h40; BranchE = 0;
    #1;
    vectors++;
    if (PCSrcE !== 1'b0) begin
      miscompares++;
      $display("FAIL no_branch pcsrc=%b, want 0", PCSrcE);
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  ops [9];
    logic [31:0] as  [9];
    logic [31:0] bs  [9];
    logic [31:0] exp [9];
    ops = '{3'b101, 3'b101, 3'b110, 3'b111, 3'b100, 3'b010, 3'b011, 3'b000, 3'b001};
    as  = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'h8000_0000, 32'hF0, 32'hF0F0, 32'hF000, 32'hFFFF_FFFF, 32'd0};
    bs  = '{32'd1, 32'hFFFF_FFFF, 32'h21, 32'd31, 32'hFF, 32'hFF00, 32'h000F, 32'd1, 32'd1};
    exp = '{32'd1, 32'd0, 32'd2, 32'd1, 32'h0F, 32'hF000, 32'hF00F, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      idle();
      ALUSrcE = 1; ALUControlE = ops[i]; RD1_E = as[i]; Imm_Ext_E = bs[i]; RD2_E = 32'hDEAD_BEEF;
      step();
      $display("alu op=%b a=%h b=%h: alu=%h", ops[i], as[i], bs[i], ALU_ResultM);
      vectors++;
      if (ALU_ResultM !== exp[i]) begin
        miscompares++;
        $display("FAIL alu_op%b alu=%h, want %h", ops[i], ALU_ResultM, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    idle();
    RD1_E = 32'h1234; ALUControlE = 3'b000;
    step();
    @(negedge clk);
    idle();
    MemWriteE = 1; ALUSrcE = 1; ForwardB_E = 2'b10; RD2_E = 32'hDEAD; RD1_E = 32'h1000;
    Imm_Ext_E = 32'd4; RD_E = 5'd9; ResultSrcE = 2'b01; PCPlus4E = 32'h204;
    step();
    $display("store: wd=%h mw=%b rd=%0d alu=%h rs=%b pc4=%h rw=%b",
             WriteDataM, MemWriteM, RD_M, ALU_ResultM, ResultSrcM, PCPlus4M, RegWriteM);
    vectors++;
    if (WriteDataM !== 32'h1234 || MemWriteM !== 1'b1 || RD_M !== 5'd9) begin
      miscompares++;
      $display("FAIL store wd=%h mw=%b rd=%0d, want 00001234 1 9", WriteDataM, MemWriteM, RD_M);
    end
    vectors++;
    if (ALU_ResultM !== 32'h1004 || ResultSrcM !== 2'b01 || PCPlus4M !== 32'h204 || RegWriteM !== 1'b0) begin
      miscompares++;
      $display("FAIL store_ctl alu=%h rs=%b pc4=%h rw=%b, want 00001004 01 00000204 0",
               ALU_ResultM, ResultSrcM, PCPlus4M, RegWriteM);
    end
  endtask

  initial begin
    idle();
    rst = 0;
    #3;
    vectors++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
      miscompares++;
      $display("FAIL initial_reset alu=%h rd=%0d, want all 0", ALU_ResultM, RD_M);
    end
    test_reset();
    test_back_to_back();
    test_wb_forward();
    test_branch();
    test_alu_ops();
    test_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the five-stage RISC-V pipelined core, sitting between the ID/EX and EX/MEM boundaries. Consumes the forwarding selects produced by the hazard unit and resolves each ALU operand from the register file, the Memory-stage ALU result or the Writeback result. Computes the ALU result, branch decision and branch target. Registers all Memory-stage signals in the EX/MEM pipeline register, whose ALU result output is also the Memory-stage forwarding source.

## Interface
- XLEN, 32, datapath width
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- RegWriteE, MemWriteE, BranchE  in  1 each  control from ID/EX
- ALUSrcE  in  1  0: operand B is forwarded RD2; 1: operand B is Imm_Ext_E
- ResultSrcE  in  2  writeback result select, passed through
- ALUControlE  in  3  ALU operation select
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  XLEN each  ID/EX data
- RD_E  in  5  destination register
- ResultW  in  XLEN  Writeback-stage result, the forwarding source for select 01
- ForwardA_E, ForwardB_E  in  2 each  forwarding selects from the hazard unit
- PCSrcE  out  1  branch taken, combinational
- PCTargetE  out  XLEN  PCE + Imm_Ext_E, combinational
- RegWriteM, MemWriteM  out  1 each  registered control
- ResultSrcM  out  2  registered
- RD_M  out  5  registered
- PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN each  registered data

## Operation
- Source A is RD1_E when the select is 00 or 11, ResultW when it is 01, and ALU_ResultM when it is 10.
- Forwarded B uses the same rule with RD2_E.
- Select 11 is illegal and is treated as 00. The block never generates X for it.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- ALUControlE encoding:
  - 000: add
  - 001: sub
  - 010: and
  - 011: or
  - 100: xor
  - 101: slt (signed compare; result is 1 or 0, zero-extended)
  - 110: sll by SrcB[4:0]
  - 111: srl by SrcB[4:0], logical
- Add and sub wrap modulo 2^XLEN. No overflow or carry output.
- Zero = (ALU result == 0). PCSrcE = Zero & BranchE, giving beq semantics.
- PCTargetE = PCE + Imm_Ext_E, wrapping modulo 2^XLEN.
- WriteDataM captures forwarded B, not SrcB. A store therefore writes the forwarded rs2 value even when ALUSrcE = 1.
- EX/MEM register, on each clk rising edge with rst high, captures:
  - RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E
  - forwarded B into WriteDataM
  - ALU result into ALU_ResultM
- There is no stall or flush input. The upstream ID/EX register inserts bubbles as all-zero control.

## Timing
- rst low clears every registered output to 0 immediately, with no clock required:
  - RegWriteM = 0, MemWriteM = 0, ResultSrcM = 00, RD_M = 0
  - PCPlus4M = 0, WriteDataM = 0, ALU_ResultM = 0
- Reset deasserting mid-operation: the first capture is on the first rising edge with rst high.
- Latency from ID/EX inputs to M outputs is exactly 1 cycle.
- PCSrcE and PCTargetE are combinational in the same cycle. They are not gated by rst.
- The ALU_ResultM feedback path uses the register's current value, i.e. the result of the instruction one ahead. A back-to-back dependent instruction therefore sees the correct operand with no bubble.
- Simultaneous 10 and 01 conditions on one operand are resolved upstream; this block obeys whatever select it receives.

## Test plan
- Reset, then back-to-back forwarding:
  - Assert rst low mid-run: all M outputs go to 0 asynchronously, before the next clk edge.
  - Release reset. Apply add with RD1_E=5, RD2_E=7, ALUSrcE=0: ALU_ResultM = 12 one cycle later.
- M-stage forwarding:
  - Following the add above, apply ForwardA_E=10, RD1_E=0, ALUSrcE=1, Imm_Ext_E=3, add.
  - Required: ALU_ResultM = 15.
- Writeback forwarding and illegal select:
  - ForwardB_E=01, ResultW=0xFFFFFFFF, RD1_E=1, sub: ALU_ResultM = 2.
  - Same stimulus with ForwardB_E=11 and RD2_E=1: ALU_ResultM = 0.
- Branch:
  - BranchE=1, sub with equal operands 0x40/0x40, PCE=0x100, Imm_Ext_E=0xFFFFFFF0: PCSrcE = 1 and PCTargetE = 0xF0, same cycle.
  - Same stimulus with unequal operands: PCSrcE = 0.
- ALU ops:
  - slt with -1 vs 1: result 1.
  - sll with 1 and SrcB = 0x21: result 2, since only SrcB[4:0] is used.
  - srl with 0x80000000 and 31: result 1.
  - xor with 0xF0 and 0xFF: result 0x0F.
- Store data:
  - MemWriteE=1, ALUSrcE=1, ForwardB_E=10, current ALU_ResultM=0x1234.
  - Required: WriteDataM = 0x1234, MemWriteM = 1, RD_M equals the registered RD_E.
